// File: rtl/instr_fetch_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {pc, instr}
// with valid/ready on both sides and a redirect flush.
module instr_fetch_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [31:0]                in_instr,
   input  logic [PC_W-1:0]            in_pc,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_instr,
   output logic [PC_W-1:0]            out_pc,
   output logic [6:0]                 out_opcode,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]     instr_q [DEPTH];
   logic [31:0]     instr_d [DEPTH];
   logic [PC_W-1:0] pc_q    [DEPTH];
   logic [PC_W-1:0] pc_d    [DEPTH];
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   logic full;
   logic empty;
   logic push;
   logic pop;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      in_ready = ~full | flush;
      push     = in_valid & ~full & ~flush & ~rst;
      pop      = out_ready & ~empty & ~flush & ~rst;

      instr_d  = instr_q;
      pc_d     = pc_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            instr_d[wr_ptr_q] = in_instr;
            pc_d[wr_ptr_q]    = in_pc;
            wr_ptr_d          = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; occupancy alone decides what is visible.
   always_ff @(posedge clk) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
   end

   always_comb begin
      out_valid  = ~empty;
      out_instr  = empty ? NOP : instr_q[rd_ptr_q];
      out_pc     = empty ? '0 : pc_q[rd_ptr_q];
      out_opcode = out_instr[6:0];
      count      = count_q;
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Randomized and directed checks of instr_fetch_queue against a
// queue-based reference model.
module tb_instr_fetch_queue;

   localparam int DEPTH = 4;
   localparam int PC_W  = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic [6:0]  out_opcode;
   logic [2:0]  count;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t q[$];
   bit   live = 1'b0;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   instr_fetch_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_instr   (in_instr),
      .in_pc      (in_pc),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_instr  (out_instr),
      .out_pc     (out_pc),
      .out_opcode (out_opcode),
      .count      (count)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input logic r, input logic f, input logic iv,
                      input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy);
      bit do_push;
      bit do_pop;
      ent_t e;
      rst       = r;
      flush     = f;
      in_valid  = iv;
      in_instr  = ins;
      in_pc     = pc;
      out_ready = ordy;
      #1;
      if (live) begin
         check("count", 64'(count), 64'(q.size()));
         check("out_valid", 64'(out_valid), 64'(q.size() != 0));
         check("in_ready", 64'(in_ready), 64'(f || q.size() != DEPTH));
         check("out_instr", 64'(out_instr),
               64'(q.size() != 0 ? q[0].instr : 32'h13));
         check("out_pc", 64'(out_pc), 64'(q.size() != 0 ? q[0].pc : 32'h0));
         check("out_opcode", 64'(out_opcode),
               64'(q.size() != 0 ? q[0].instr[6:0] : 7'h13));
      end
      do_push = iv && q.size() < DEPTH;
      do_pop  = ordy && q.size() > 0;
      @(posedge clk);
      if (r || f) begin
         q.delete();
      end else begin
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.pc    = pc;
            e.instr = ins;
            q.push_back(e);
         end
      end
      if (r) live = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      @(negedge clk);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      // Fill with decode stalled, then one refused push while full.
      for (int i = 0; i < 4; i++)
         cyc(0, 0, 1, $urandom, 32'(i * 4), 0);
      cyc(0, 0, 1, 32'hdead_beef, 32'h100, 0);
      check("full_count", 64'(count), 64'd4);
      check("full_in_ready", 64'(in_ready), 64'd0);
      check("full_head_pc", 64'(out_pc), 64'h0);
      for (int i = 0; i < 4; i++) begin
         check("drain_pc", 64'(out_pc), 64'(i * 4));
         cyc(0, 0, 0, 0, 0, 1);
      end
      check("drain_empty", 64'(out_valid), 64'd0);
      check("drain_nop", 64'(out_instr), 64'h13);
      cyc(0, 0, 1, $urandom, 32'h200, 0);
      cyc(0, 0, 1, $urandom, 32'h204, 0);
      for (int i = 0; i < 10; i++)
         cyc(0, 0, 1, $urandom, 32'(32'h208 + i * 4), 1);
      check("steady_count", 64'(count), 64'd2);
      cyc(0, 0, 1, $urandom, 32'h300, 0);
      cyc(0, 1, 1, 32'h1234_5678, 32'h400, 1);
      check("flush_count", 64'(count), 64'd0);
      check("flush_valid", 64'(out_valid), 64'd0);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 1, 32'hFFC1_0113, 32'h500, 0);
      check("addi_valid", 64'(out_valid), 64'd1);
      check("addi_instr", 64'(out_instr), 64'hFFC1_0113);
      check("addi_opcode", 64'(out_opcode), 64'h13);
      cyc(0, 0, 1, $urandom, 32'h504, 0);
      cyc(1, 0, 1, $urandom, 32'h508, 0);
      check("rst_count", 64'(count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_out_pc", 64'(out_pc), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      for (int i = 0; i < 3000; i++)
         cyc($urandom_range(0, 99) == 0, $urandom_range(0, 99) < 4,
             $urandom_range(0, 99) < 60, $urandom, $urandom,
             $urandom_range(0, 99) < 50);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
